// File: rtl/ps2_host_tx_pkg.sv
// Shared definitions for the PS/2 host transmitter: FSM state encoding, common
// keyboard command/response bytes and the frame builder used when a byte is accepted.
package ps2_host_tx_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StInhibit,
    StReq,
    StSend,
    StAck,
    StWaitIdle
  } ps2_state_e;

  localparam logic [7:0] CmdSetLeds = 8'hED;
  localparam logic [7:0] CmdReset   = 8'hFF;
  localparam logic [7:0] CmdEnable  = 8'hF4;
  localparam logic [7:0] RspAck     = 8'hFA;

  // Shift-out order is bit 0 first: data[7:0], odd parity, stop (1 = released).
  function automatic logic [9:0] ps2_frame(input logic [7:0] data);
    return {1'b1, ~^data, data};
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Byte request/response handshake between a command source and the PS/2 host transmitter.
//   tx_data/tx_valid : request from the master, accepted when tx_valid & tx_ready
//   tx_ready         : transmitter idle and able to accept
//   tx_done/tx_error : one-cycle completion pulses (ACKed / timeout or no ACK)
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_done;
  logic       tx_error;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready,
    input  tx_done,
    input  tx_error
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    output tx_done,
    output tx_error
  );
endinterface

// File: rtl/ps2_host_tx_sync_edge.sv
// Multi-stage synchronizer for an asynchronous PS/2 line with falling-edge detect.
//   clk_i, rst_ni : system clock, async active-low reset (line assumed high/idle)
//   line_i        : raw asynchronous line
//   level_o       : synchronized level
//   fall_o        : one-cycle pulse when the synchronized level goes 1 -> 0
// Stages must be at least 2.
module ps2_host_tx_sync_edge #(
  parameter int unsigned Stages = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic line_i,
  output logic level_o,
  output logic fall_o
);

  logic [Stages-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[Stages-2:0], line_i};
      prev_q <= sync_q[Stages-1];
    end
  end

  assign level_o = sync_q[Stages-1];
  assign fall_o  = prev_q & ~sync_q[Stages-1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter. Sends one byte using the request-to-send sequence:
// inhibit clock, assert start bit, release clock, then shift bits on device clock falls
// and check the device ACK. Lines are driven only through pull-low enables; the
// open-drain tri-state (line = oe ? 0 : z) lives in the board top level.
//   clk_i, rst_ni      : system clock, async active-low reset
//   tx_if (slave)      : byte request handshake and done/error pulses
//   busy_o             : transfer in progress (including the completion-pulse cycle)
//   rx_inhibit_o       : same as busy_o, holds off the receive path
//   ps2_clk_i/data_i   : raw PS/2 lines (asynchronous)
//   ps2_clk_oe_o/..    : 1 = pull the line low, 0 = release
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int unsigned InhibitCycles = 6000,
  parameter int unsigned TimeoutCycles = 750000,
  parameter int unsigned SyncStages    = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  ps2_host_tx_if.slave tx_if,
  output logic         busy_o,
  output logic         rx_inhibit_o,
  input  logic         ps2_clk_i,
  input  logic         ps2_data_i,
  output logic         ps2_clk_oe_o,
  output logic         ps2_data_oe_o
);

  localparam int unsigned InhW = $clog2(InhibitCycles);
  localparam int unsigned TmoW = $clog2(TimeoutCycles + 1);
  localparam logic [InhW-1:0] InhLast = InhW'(InhibitCycles - 1);
  localparam logic [InhW-1:0] InhPre  = InhW'(InhibitCycles - 2);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TimeoutCycles - 1);
  localparam logic [TmoW-1:0] TmoMax  = TmoW'(TimeoutCycles);

  ps2_state_e      state_q;
  logic [9:0]      shift_q;
  logic [InhW-1:0] inh_cnt_q;
  logic [TmoW-1:0] tmo_cnt_q;
  logic [3:0]      edge_cnt_q;
  logic            clk_oe_q, data_oe_q, done_q, error_q;

  logic clk_lvl, clk_fall, data_lvl, data_fall_unused;
  logic ready, accept, active;

  ps2_host_tx_sync_edge #(.Stages(SyncStages)) u_sync_clk (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .line_i (ps2_clk_i),
    .level_o(clk_lvl),
    .fall_o (clk_fall)
  );

  // Only the data level matters (ACK sample and idle check).
  ps2_host_tx_sync_edge #(.Stages(SyncStages)) u_sync_data (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .line_i (ps2_data_i),
    .level_o(data_lvl),
    .fall_o (data_fall_unused)
  );

  // Ready stays low through the done/error pulse so the pulse precedes ready.
  assign ready  = (state_q == StIdle) & ~done_q & ~error_q;
  assign accept = tx_if.tx_valid & ready;
  assign active = (state_q == StReq) | (state_q == StSend) |
                  (state_q == StAck) | (state_q == StWaitIdle);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      shift_q    <= '0;
      inh_cnt_q  <= '0;
      tmo_cnt_q  <= '0;
      edge_cnt_q <= '0;
      clk_oe_q   <= 1'b0;
      data_oe_q  <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
      if (active) begin
        tmo_cnt_q <= (tmo_cnt_q == TmoMax) ? tmo_cnt_q : tmo_cnt_q + 1'b1;
      end

      if (active && (tmo_cnt_q == TmoLast)) begin
        clk_oe_q  <= 1'b0;
        data_oe_q <= 1'b0;
        error_q   <= 1'b1;
        state_q   <= StIdle;
      end else begin
        case (state_q)
          StIdle: begin
            if (accept) begin
              shift_q   <= ps2_frame(tx_if.tx_data);
              inh_cnt_q <= '0;
              clk_oe_q  <= 1'b1;
              state_q   <= StInhibit;
            end
          end
          StInhibit: begin
            inh_cnt_q <= inh_cnt_q + 1'b1;
            // Start bit goes out during the last inhibit cycle.
            if (inh_cnt_q == InhPre) data_oe_q <= 1'b1;
            if (inh_cnt_q == InhLast) begin
              clk_oe_q   <= 1'b0;
              tmo_cnt_q  <= '0;
              edge_cnt_q <= '0;
              state_q    <= StReq;
            end
          end
          StReq, StSend: begin
            if (clk_fall) begin
              edge_cnt_q <= edge_cnt_q + 4'd1;
              data_oe_q  <= ~shift_q[0];
              shift_q    <= {1'b0, shift_q[9:1]};
              if (state_q == StReq) state_q <= StSend;
              else if (edge_cnt_q == 4'd9) state_q <= StAck;
            end
          end
          StAck: begin
            if (clk_fall) begin
              edge_cnt_q <= edge_cnt_q + 4'd1;
              if (!data_lvl) begin
                state_q <= StWaitIdle;
              end else begin
                error_q <= 1'b1;
                state_q <= StIdle;
              end
            end
          end
          StWaitIdle: begin
            if (clk_lvl && data_lvl) begin
              done_q  <= 1'b1;
              state_q <= StIdle;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign tx_if.tx_ready = ready;
  assign tx_if.tx_done  = done_q;
  assign tx_if.tx_error = error_q;
  assign busy_o         = ~ready;
  assign rx_inhibit_o   = ~ready;
  assign ps2_clk_oe_o   = clk_oe_q;
  assign ps2_data_oe_o  = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: behavioural PS/2 device model on wired-AND
// lines, scoreboard of expected outcomes/frames, and a monitor that pops on each pulse.
module tb_ps2_host_tx;
  import ps2_host_tx_pkg::*;

  localparam int unsigned Inh    = 1200;
  localparam int unsigned Tmo    = 5000;
  localparam int unsigned Half   = 15;
  localparam int          Budget = 12000;

  typedef struct {
    logic [9:0] bits;
    bit         is_err;
    bit         chk_frame;
    int         id;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ps2_host_tx_if tx_if ();
  logic busy, rx_inh, clk_oe, data_oe;
  logic dev_clk_pull = 1'b0, dev_data_pull = 1'b0;
  logic clk_line, data_line;
  assign clk_line  = ~(clk_oe | dev_clk_pull);
  assign data_line = ~(data_oe | dev_data_pull);

  ps2_host_tx #(
    .InhibitCycles(Inh),
    .TimeoutCycles(Tmo),
    .SyncStages   (2)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .tx_if        (tx_if),
    .busy_o       (busy),
    .rx_inhibit_o (rx_inh),
    .ps2_clk_i    (clk_line),
    .ps2_data_i   (data_line),
    .ps2_clk_oe_o (clk_oe),
    .ps2_data_oe_o(data_oe)
  );

  int checks = 0, failures = 0;
  exp_t exp_q[$];
  logic [9:0] cap_q[$];
  int pulses = 0, dones = 0, inh_starts = 0, frame_id = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, want);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    failures++;
    $display("FAIL %s: got no event, want event within bound", nm);
  endtask

  // Frame as seen on the wire: data LSB first, odd parity, stop bit 1.
  function automatic logic [9:0] ref_frame(input logic [7:0] d);
    logic par;
    par = ($countones(d) % 2 == 0);
    return {1'b1, par, d};
  endfunction

  // ---------------- monitor / scoreboard ----------------
  int inh_run = 0, dat_run = 0;
  logic prev_clk_oe = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      inh_run = 0;
      dat_run = 0;
      prev_clk_oe = 1'b0;
    end else begin
      if (tx_if.tx_done || tx_if.tx_error) begin
        pulses++;
        if (tx_if.tx_done) dones++;
        chk("done_error_exclusive", 32'(tx_if.tx_done & tx_if.tx_error), 32'd0);
        chk("ready_low_during_pulse", 32'(tx_if.tx_ready), 32'd0);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_pulse: got done=%0b error=%0b, want none",
                   tx_if.tx_done, tx_if.tx_error);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("frame%0d_error_flag", e.id), 32'(tx_if.tx_error), 32'(e.is_err));
          if (e.chk_frame) begin
            if (cap_q.size() == 0) begin
              fail($sformatf("frame%0d_captured", e.id));
            end else begin
              chk($sformatf("frame%0d_bits", e.id), 32'(cap_q.pop_front()), 32'(e.bits));
            end
          end
        end
      end
      if (clk_oe) begin
        if (!prev_clk_oe) inh_starts++;
        inh_run++;
        if (data_oe) dat_run++;
      end else if (prev_clk_oe) begin
        chk("inhibit_width", 32'(inh_run), 32'(Inh));
        chk("start_bit_lead", 32'(dat_run), 32'd1);
        inh_run = 0;
        dat_run = 0;
      end
      prev_clk_oe = clk_oe;
    end
  end

  // ---------------- PS/2 device model ----------------
  // dev_mode: 0 = normal with ACK, 1 = never clocks, 2 = clocks but no ACK.
  int dev_mode = 0;
  int dev_edge = 0;
  bit dev_abort = 1'b0;

  task automatic dev_wait(input int n);
    for (int i = 0; i < n; i++) begin
      if (dev_abort) return;
      @(negedge clk);
      if (!rst_n) dev_abort = 1'b1;
    end
  endtask

  initial begin : device
    logic [9:0] bits;
    forever begin
      @(negedge clk);
      if (rst_n && clk_line && !data_line) begin
        if (dev_mode == 1) begin
          while (!data_line) @(negedge clk);
        end else begin
          dev_abort = 1'b0;
          bits = '0;
          dev_wait(Half);
          for (int k = 1; k <= 11 && !dev_abort; k++) begin
            dev_clk_pull = 1'b1;
            dev_edge = k;
            dev_wait(Half);
            if (k <= 10) bits[k-1] = data_line;
            if (k == 10 && !dev_abort) cap_q.push_back(bits);
            dev_clk_pull = 1'b0;
            if (k == 10 && dev_mode == 0) begin
              dev_wait(Half / 2);
              dev_data_pull = 1'b1;
              dev_wait(Half - Half / 2);
            end else begin
              dev_wait(Half);
            end
          end
          dev_clk_pull = 1'b0;
          dev_data_pull = 1'b0;
          dev_edge = 0;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [7:0] d, input int mode, input bit push);
    exp_t e;
    int n;
    n = 0;
    while (!tx_if.tx_ready && n < Budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= Budget) fail("ready_before_send");
    dev_mode = mode;
    if (push) begin
      e.bits = ref_frame(d);
      e.is_err = (mode != 0);
      e.chk_frame = (mode != 1);
      e.id = frame_id;
      exp_q.push_back(e);
    end
    frame_id++;
    tx_if.tx_data = d;
    tx_if.tx_valid = 1'b1;
    @(negedge clk);
    tx_if.tx_valid = 1'b0;
    tx_if.tx_data = 8'($urandom);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < Budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= Budget) begin
      fail("frame_completion");
      exp_q.delete();
      cap_q.delete();
    end
    repeat (40) @(negedge clk);
  endtask

  initial begin : stim
    logic [7:0] d;
    int n, p0, d0, s0;
    tx_if.tx_valid = 1'b0;
    tx_if.tx_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_ready", 32'(tx_if.tx_ready), 32'd1);
    chk("reset_done_error", 32'({tx_if.tx_done, tx_if.tx_error}), 32'd0);
    chk("reset_busy_inhibit", 32'({busy, rx_inh}), 32'd0);
    chk("reset_oe", 32'({clk_oe, data_oe}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    send(CmdSetLeds, 0, 1);
    chk("busy_after_accept", 32'({busy, rx_inh, clk_oe}), 32'h7);
    wait_done();
    send(8'h01, 0, 1); wait_done();
    send(8'h00, 0, 1); wait_done();
    send(RspAck, 0, 1); wait_done();
    for (int i = 0; i < 4; i++) begin
      d = 8'($urandom_range(0, 255));
      send(d, 0, 1);
      wait_done();
    end

    // Device never clocks: error exactly Tmo cycles after clock release.
    send(8'h3C, 1, 1);
    n = 0;
    while (clk_oe && n < Inh + 50) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (!tx_if.tx_error && n < Tmo + 100) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_latency", 32'(n), 32'(Tmo));
    chk("timeout_oe_released", 32'({clk_oe, data_oe}), 32'd0);
    @(negedge clk);
    chk("timeout_ready_back", 32'(tx_if.tx_ready), 32'd1);
    wait_done();

    // No ACK at edge 11.
    d0 = dones;
    send(8'hA7, 2, 1);
    wait_done();
    chk("noack_no_done", 32'(dones - d0), 32'd0);

    // Second request during a frame is ignored.
    s0 = inh_starts;
    send(CmdReset, 0, 1);
    repeat (100) @(negedge clk);
    chk("ready_low_while_busy", 32'(tx_if.tx_ready), 32'd0);
    tx_if.tx_data = 8'h55;
    tx_if.tx_valid = 1'b1;
    @(negedge clk);
    tx_if.tx_valid = 1'b0;
    wait_done();
    repeat (300) @(negedge clk);
    chk("single_frame_for_ff", 32'(inh_starts - s0), 32'd1);
    chk("no_extra_capture", 32'(cap_q.size()), 32'd0);

    // Reset during edge 5.
    send(8'hA5, 0, 0);
    n = 0;
    while (dev_edge != 5 && n < Budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= Budget) fail("reach_edge5");
    repeat (5) @(negedge clk);
    p0 = pulses;
    #2;
    rst_n = 1'b0;
    #1;
    chk("reset_mid_frame_oe", 32'({clk_oe, data_oe}), 32'd0);
    chk("reset_mid_frame_ready", 32'(tx_if.tx_ready), 32'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    chk("reset_no_pulse", 32'(pulses - p0), 32'd0);
    cap_q.delete();
    send(CmdEnable, 0, 1);
    wait_done();

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) to the keyboard over the shared PS/2 clock/data lines using the open-drain request-to-send protocol. Sits beside `PS2_Interface` in the top level. It drives the lines only through active-high pull-low enables, and it holds off the receiver while a frame is in flight. Device response bytes (0xFA ACK, etc.) are received by the existing receive path, not by this block.

## Interface
- `INHIBIT_CYCLES`, 6000: cycles clock is held low before the request (120 µs at 50 MHz).
- `TIMEOUT_CYCLES`, 750000: maximum cycles from clock release to device ACK (15 ms at 50 MHz).
- `SYNC_STAGES`, 2: synchronizer depth on the line inputs.

Ports:
- `clock`  in  1  system clock, `CLOCK_50` domain.
- `resetn`  in  1  asynchronous, active-low reset.
- `tx_data`  in  8  byte to send; sampled on accept.
- `tx_valid`  in  1  request; accepted when `tx_valid & tx_ready`.
- `tx_ready`  out  1  high only in IDLE.
- `tx_done`  out  1  one-cycle pulse: frame ACKed by the device and lines idle.
- `tx_error`  out  1  one-cycle pulse: timeout or missing ACK.
- `busy`  out  1  high in every state except IDLE.
- `rx_inhibit`  out  1  equals `busy`; gates the receiver.
- `ps2_clk_in`  in  1  raw PS/2 clock line, asynchronous.
- `ps2_data_in`  in  1  raw PS/2 data line, asynchronous.
- `ps2_clk_oe`  out  1  1 = pull clock low; 0 = release.
- `ps2_data_oe`  out  1  1 = pull data low; 0 = release.

Reset values: `tx_ready`=1, all other outputs 0, and the state is IDLE.

## Operation
- Frame: start bit 0, data[7:0] LSB first, odd parity (`~^tx_data`), stop bit 1 (line released), then the device ACK (device pulls data low).
- **IDLE**: both lines released.
  - On accept, latch `tx_data` and the parity bit into a 10-bit shift register `{1, parity, data}`.
  - Go to INHIBIT.
- **INHIBIT**: `clk_oe`=1 for `INHIBIT_CYCLES`.
  - In the final cycle, set `data_oe`=1 (start bit).
  - Go to REQ.
- **REQ/SEND**: set `clk_oe`=0 and keep `data_oe`=1.
  - Clear the timeout counter.
  - Count synchronized falling edges of the PS/2 clock (edge counter 1..11).
  - Edges 1–8: drive `data_oe` = ~bit. Edge 9: parity. Edge 10: stop, so `data_oe`=0.
  - Update only on the falling edge; the device samples on the rising edge.
- **ACK**: at falling edge 11, sample synchronized data.
  - Data 0: go to WAIT_IDLE.
  - Data 1: pulse `tx_error` and go to IDLE.
- **WAIT_IDLE**: wait until synchronized clock and data are both high, then pulse `tx_done` and go to IDLE.
- **Timeout**: in REQ/SEND/ACK/WAIT_IDLE, reaching `TIMEOUT_CYCLES` does the following:
  - releases both lines;
  - pulses `tx_error`;
  - returns to IDLE.
- `tx_valid` while busy: ignored, with no queueing.
- `tx_done` and `tx_error` are mutually exclusive.
- Reset mid-frame: lines released immediately (asynchronously), state IDLE, no pulse.

## Timing
- Accept to `clk_oe` rising: 1 cycle (registered).
- `clk_oe` low width: exactly `INHIBIT_CYCLES`.
- `data_oe` rises 1 cycle before `clk_oe` falls.
- Edge detection latency: `SYNC_STAGES`+1 cycles after a raw line transition. Update `data_oe` in the same cycle the edge is detected.
- `tx_done` / `tx_error`: one cycle wide, registered, asserted the cycle before `tx_ready` returns to 1.
- Counters:
  - inhibit counter is `$clog2(INHIBIT_CYCLES)` bits;
  - timeout counter is `$clog2(TIMEOUT_CYCLES+1)` bits and saturates;
  - edge counter is 4 bits.
- Glitches shorter than `SYNC_STAGES` cycles are not filtered beyond the synchronizer.

## Structure
- Shared header `ps2_defs`:
  - state encodings (IDLE, INHIBIT, REQ, SEND, ACK, WAIT_IDLE);
  - command constants CMD_SET_LEDS=0xED, CMD_RESET=0xFF, CMD_ENABLE=0xF4;
  - response constant RSP_ACK=0xFA.
- Sub-module `ps2_sync_edge`, instantiated twice (clock, data):
  - an N-stage synchronizer;
  - outputs the synchronized level and a one-cycle falling-edge pulse;
  - resets to level 1.
- Top-level tri-state: `ps2_clock = ps2_clk_oe ? 1'b0 : 1'bz`, and likewise for data.

## Test plan
- **Send 0xED**, device model ACKs. Required response:
  - the model captures bits 1,0,1,1,0,1,1,1, parity 1, stop 1;
  - `tx_done` pulses once;
  - `clk_oe` was low for exactly 6000 cycles.
- **Send 0x01**: parity bit 0. **Send 0x00**: parity bit 1. Both complete with `tx_done`.
- **Device never clocks**: `tx_error` pulses at 750000 cycles after clock release, both `oe`=0, and `tx_ready`=1.
- **Device leaves data high at edge 11 (no ACK)**: `tx_error` pulses, and `tx_done` stays 0.
- **`tx_valid` pulsed with 0x55 during a 0xFF frame**: ignored; only 0xFF is transmitted.
- **`resetn` asserted at edge 5**: both `oe`=0 within the same cycle, with no `tx_done` or `tx_error`. After release, a new 0xF4 transfer completes.
